// File: rtl/pc_fetch_pkg.sv
// Shared constants for the instruction-fetch sequencer.
// No logic; state encodings, next-address select codes and defaults.
// Imported by pc_fetch_ctrl and pc_next_sel.
package pc_fetch_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    // Next-address select codes for pc_next_sel
    localparam logic [1:0] SEL_HOLD = 2'd0;
    localparam logic [1:0] SEL_SEQ  = 2'd1;
    localparam logic [1:0] SEL_BR   = 2'd2;

    localparam int          INSTR_BYTES_DFLT  = 4;
    localparam logic [31:0] RESET_VECTOR_DFLT = 32'h0;

endpackage

// File: rtl/pc_next_sel.sv
// Next-address select: hold, sequential increment, or word-aligned branch target.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module pc_next_sel
    import pc_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_BYTES = INSTR_BYTES_DFLT
) (
    input  logic [1:0]            sel_i,
    input  logic [ADDR_WIDTH-1:0] cur_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    output logic [ADDR_WIDTH-1:0] next_o
);

    // Low two target bits are forced to zero; the increment wraps naturally modulo 2^ADDR_WIDTH.
    always_comb begin
        next_o = cur_i;
        case (sel_i)
            SEL_SEQ: next_o = cur_i + ADDR_WIDTH'(INSTR_BYTES);
            SEL_BR:  next_o = target_i & ~ADDR_WIDTH'(3);
            default: next_o = cur_i;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns pc, issues one imem read at a time, feeds decode via output+skid buffer.
// Latency: fetched word is valid on the edge its ack completes; zero-wait memory gives one word per cycle.
// Backpressure: stall holds the output; a second word parks in the skid and requests pause until consumed.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(RESET_VECTOR_DFLT),
    parameter int                    INSTR_BYTES  = INSTR_BYTES_DFLT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [ADDR_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  out_vld_q, out_vld_d;
    logic [ADDR_WIDTH-1:0] out_dat_q, out_dat_d;
    logic [ADDR_WIDTH-1:0] out_pc_q, out_pc_d;
    logic                  skid_vld_q, skid_vld_d;
    logic [ADDR_WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [1:0]            pc_sel;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  req_active;
    logic                  consume;

    assign req_active = (state_q == ST_REQ) || (state_q == ST_FLUSH);
    assign consume    = out_vld_q && !stall;

    pc_next_sel #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_next_sel (
        .sel_i    (pc_sel),
        .cur_i    (pc_q),
        .target_i (branch_target),
        .next_o   (pc_next)
    );

    assign pc_d = pc_next;

    // FSM, address and buffer next-state; a branch overrides stall and ack.
    always_comb begin
        state_d    = state_q;
        pc_sel     = SEL_HOLD;
        addr_d     = addr_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        out_pc_d   = out_pc_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        skid_pc_d  = skid_pc_q;

        if (branch_valid) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
            pc_sel     = SEL_BR;
            if (req_active && !imem_ack) begin
                // Read still outstanding: keep imem_addr stable and drain it.
                state_d = ST_FLUSH;
            end else begin
                state_d = ST_REQ;
                addr_d  = pc_next;
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (consume) out_vld_d = 1'b0;
                    if (imem_ack) begin
                        pc_sel = SEL_SEQ;
                        addr_d = pc_next;
                        if (!out_vld_q || consume) begin
                            out_vld_d = 1'b1;
                            out_dat_d = imem_rdata;
                            out_pc_d  = addr_q;
                        end else begin
                            skid_vld_d = 1'b1;
                            skid_dat_d = imem_rdata;
                            skid_pc_d  = addr_q;
                            state_d    = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (consume) begin
                        out_dat_d  = skid_dat_q;
                        out_pc_d   = skid_pc_q;
                        skid_vld_d = 1'b0;
                        state_d    = ST_REQ;
                    end
                end
                default: begin
                    // FLUSH: the returning word is dropped, then fetch resumes at pc.
                    if (consume) out_vld_d = 1'b0;
                    if (imem_ack) begin
                        state_d = ST_REQ;
                        addr_d  = pc_q;
                    end
                end
            endcase
        end
    end

    // State registers; reset abandons any outstanding read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            addr_q     <= RESET_VECTOR;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_pc_q   <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            skid_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_pc_q   <= out_pc_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            skid_pc_q  <= skid_pc_d;
        end
    end

    assign imem_req    = req_active;
    assign imem_addr   = addr_q;
    assign pc          = pc_q;
    assign instr_valid = out_vld_q;
    assign instr       = out_dat_q;
    assign instr_pc    = out_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: sequential fetch, stall/skid, branch flush, reset.
// Inputs change 1ns after the rising edge; outputs are checked at that same point.
// A second instance with RESET_VECTOR=0xFFFFFFFC checks address wrap.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_ack;
    logic        rdata_ovr;
    logic [31:0] imem_rdata;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc, pc;
    logic        w_req, w_vld;
    logic [31:0] w_addr, w_instr, w_ipc, w_pc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Memory returns a tag of the address so order and content are checkable.
    assign imem_rdata = rdata_ovr ? 32'h0000DEAD : (imem_addr ^ 32'hC0DE0000);

    pc_fetch_ctrl u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc            (pc)
    );

    pc_fetch_ctrl #(.RESET_VECTOR(32'hFFFFFFFC)) u_wrap (
        .clk           (clk),
        .reset_n       (reset_n),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (w_vld),
        .instr         (w_instr),
        .instr_pc      (w_ipc),
        .pc            (w_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; branch_valid = 1'b0; branch_target = '0;
        stall = 1'b0; imem_ack = 1'b1; rdata_ovr = 1'b0;
        tick(); tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_vld", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_wrap_addr", w_addr, 32'hFFFFFFFC);
        reset_n = 1'b1;

        // Zero-wait fetch
        tick();  // E1: IDLE->REQ
        chk("e1_req", {31'b0, imem_req}, 32'd1);
        chk("e1_addr", imem_addr, 32'h0);
        chk("e1_vld", {31'b0, instr_valid}, 32'd0);
        chk("e1_wrap_addr", w_addr, 32'hFFFFFFFC);
        tick();  // E2: word @0
        chk("e2_vld", {31'b0, instr_valid}, 32'd1);
        chk("e2_ipc", instr_pc, 32'h0);
        chk("e2_instr", instr, 32'hC0DE0000);
        chk("e2_addr", imem_addr, 32'h4);
        chk("e2_pc", pc, 32'h4);
        chk("e2_wrap_addr", w_addr, 32'h0);
        chk("e2_wrap_pc", w_pc, 32'h0);
        tick();  // E3: word @4
        chk("e3_vld", {31'b0, instr_valid}, 32'd1);
        chk("e3_ipc", instr_pc, 32'h4);
        chk("e3_addr", imem_addr, 32'h8);

        // Stall: word @8 parks in skid, requests pause
        stall = 1'b1;
        tick();  // E4
        chk("e4_req", {31'b0, imem_req}, 32'd0);
        chk("e4_ipc", instr_pc, 32'h4);
        chk("e4_addr", imem_addr, 32'hC);
        tick();  // E5
        chk("e5_req", {31'b0, imem_req}, 32'd0);
        chk("e5_ipc", instr_pc, 32'h4);
        chk("e5_instr", instr, 32'hC0DE0004);
        tick();  // E6
        chk("e6_vld", {31'b0, instr_valid}, 32'd1);
        chk("e6_ipc", instr_pc, 32'h4);
        stall = 1'b0;
        tick();  // E7: skid -> output, back to REQ
        chk("e7_ipc", instr_pc, 32'h8);
        chk("e7_instr", instr, 32'hC0DE0008);
        chk("e7_req", {31'b0, imem_req}, 32'd1);
        chk("e7_addr", imem_addr, 32'hC);
        tick();  // E8: word @C
        chk("e8_ipc", instr_pc, 32'hC);
        chk("e8_addr", imem_addr, 32'h10);

        // Branch with a read outstanding
        imem_ack = 1'b0;
        tick();  // E9: consume, nothing new
        chk("e9_vld", {31'b0, instr_valid}, 32'd0);
        chk("e9_addr", imem_addr, 32'h10);
        branch_valid = 1'b1; branch_target = 32'h103;
        tick();  // E10: REQ->FLUSH
        chk("e10_pc", pc, 32'h100);
        chk("e10_addr", imem_addr, 32'h10);
        chk("e10_req", {31'b0, imem_req}, 32'd1);
        branch_valid = 1'b0;
        tick();  // E11: still waiting
        chk("e11_vld", {31'b0, instr_valid}, 32'd0);
        imem_ack = 1'b1; rdata_ovr = 1'b1;
        tick();  // E12: flushed ack, 0xDEAD dropped
        rdata_ovr = 1'b0;
        chk("e12_vld", {31'b0, instr_valid}, 32'd0);
        chk("e12_addr", imem_addr, 32'h100);
        chk("e12_pc", pc, 32'h100);
        tick();  // E13: word @100
        chk("e13_ipc", instr_pc, 32'h100);
        chk("e13_instr", instr, 32'hC0DE0100);
        chk("e13_addr", imem_addr, 32'h104);

        // Two branches during FLUSH: latest wins
        imem_ack = 1'b0;
        tick();  // E14
        chk("e14_vld", {31'b0, instr_valid}, 32'd0);
        branch_valid = 1'b1; branch_target = 32'h200;
        tick();  // E15
        chk("e15_pc", pc, 32'h200);
        chk("e15_addr", imem_addr, 32'h104);
        branch_target = 32'h300;
        tick();  // E16
        chk("e16_pc", pc, 32'h300);
        chk("e16_addr", imem_addr, 32'h104);
        branch_valid = 1'b0; imem_ack = 1'b1;
        tick();  // E17
        chk("e17_addr", imem_addr, 32'h300);
        chk("e17_vld", {31'b0, instr_valid}, 32'd0);
        tick();  // E18: word @300
        chk("e18_ipc", instr_pc, 32'h300);

        // Fill both entries, then reset asynchronously
        stall = 1'b1;
        tick();  // E19: skid takes @304, HOLD
        chk("e19_req", {31'b0, imem_req}, 32'd0);
        chk("e19_ipc", instr_pc, 32'h300);
        reset_n = 1'b0;
        #2;
        chk("ar_vld", {31'b0, instr_valid}, 32'd0);
        chk("ar_instr", instr, 32'h0);
        chk("ar_ipc", instr_pc, 32'h0);
        chk("ar_addr", imem_addr, 32'h0);
        chk("ar_pc", pc, 32'h0);
        chk("ar_req", {31'b0, imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();  // IDLE->REQ
        chk("rr1_addr", imem_addr, 32'h0);
        chk("rr1_req", {31'b0, imem_req}, 32'd1);
        tick();
        chk("rr2_ipc", instr_pc, 32'h0);
        chk("rr2_vld", {31'b0, instr_valid}, 32'd1);
        tick();
        chk("rr3_ipc", instr_pc, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
